// File: rtl/uart_rx_unit_if.sv
// -----------------------------------------------------------------------------
// uart_rx_unit_if
//   Groups the serial line and the peripheral-side receive signals of
//   uart_rx_unit so the receiver and its bus wrapper share one port.
//
//   din        serial line into the receiver, idle high, asynchronous to clk
//   rx_ack     one-cycle read strobe from the peripheral register map
//   rx_data    last correctly framed byte
//   rx_ready   unread byte held in rx_data (also the RX interrupt request)
//   rx_overrun sticky: a byte completed while the previous one was unread
//   frame_err  one-cycle pulse: stop bit sampled low
//   rx_busy    receiver is somewhere other than IDLE
//
//   master : peripheral / line side (drives din, rx_ack)
//   slave  : the receiver itself
// -----------------------------------------------------------------------------
interface uart_rx_unit_if;
  logic       din;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overrun;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output din, rx_ack,
    input  rx_data, rx_ready, rx_overrun, frame_err, rx_busy
  );

  modport slave (
    input  din, rx_ack,
    output rx_data, rx_ready, rx_overrun, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_unit.sv
// -----------------------------------------------------------------------------
// uart_rx_unit
//   8N1 asynchronous serial receiver, LSB first. din is brought into the clk
//   domain by a two-flop synchroniser; the start bit is re-checked at its
//   middle, then each data bit and the stop bit are sampled one bit period
//   apart, i.e. at mid-bit. A received byte is held until the CPU acks it.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//     CNT_W         bit-timing counter width, 2**CNT_W > CLKS_PER_BIT
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    uart_rx_unit_if.slave (din, rx_ack in; rx_data, rx_ready,
//            rx_overrun, frame_err, rx_busy out)
// -----------------------------------------------------------------------------
module uart_rx_unit #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic             sync1_q, din_s_q;
  logic             done;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: both synchroniser flops reset to the idle line level (1) so
      // a frame cannot appear to start the moment reset is released.
      sync1_q   <= 1'b1;
      din_s_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.din;
      din_s_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!din_s_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the line at the middle of the start bit; a high level
        // here means the falling edge was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = din_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = din_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (din_s_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        cnt_d = '0;
        if (din_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // A completion on the same edge as an ack replaces the byte being read,
    // so nothing is lost and no overrun is flagged.
    if (done) begin
      data_d  = shift_q;
      ready_d = 1'b1;
      if (ready_q && !bus.rx_ack) overrun_d = 1'b1;
    end else if (bus.rx_ack) begin
      ready_d = 1'b0;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_ready   = ready_q;
  assign bus.rx_overrun = overrun_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_unit
//   Two receivers share clk/reset: u_dut16 (16 clocks per bit) for the
//   single-frame scenarios and u_dut4 (4 clocks per bit) for back-to-back
//   frames. Stimulus pushes each byte it expects to be delivered into a
//   per-receiver queue; a monitor pops and compares whenever rx_ready rises.
// -----------------------------------------------------------------------------
module tb_uart_rx_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_unit_if if16();
  uart_rx_unit_if if4();

  uart_rx_unit #(.CLKS_PER_BIT(16), .CNT_W(5)) u_dut16 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if16)
  );

  uart_rx_unit #(.CLKS_PER_BIT(4), .CNT_W(3)) u_dut4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if4)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q16[$];
  logic [7:0] q4[$];
  int         ferr16 = 0;
  int         ferr4  = 0;
  logic       prev_rdy16 = 1'b0;
  logic       prev_rdy4  = 1'b0;
  int         rise_cyc16 = 0;
  int         fall16     = 0;
  bit         auto_ack4  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) if4.din = v;
    else     if16.din = v;
  endtask

  // Sends one frame; leaves the line at the stop-bit level.
  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop_v);
    int cpb;
    cpb = sel ? 4 : 16;
    drive(sel, 1'b0);
    if (!sel) fall16 = cyc;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      tick(cpb);
    end
    drive(sel, stop_v);
    tick(cpb);
  endtask

  task automatic ack16();
    if16.rx_ack = 1'b1;
    tick(1);
    if16.rx_ack = 1'b0;
  endtask

  // Monitors: score delivered bytes and count frame_err pulses.
  always @(negedge clk) begin
    if (if16.frame_err) ferr16++;
    if (if16.rx_ready && !prev_rdy16) begin
      rise_cyc16 = cyc;
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut16_unexpected_byte: got 0x%0h, expected no byte", if16.rx_data);
      end else begin
        check("dut16_rx_data", if16.rx_data, q16.pop_front());
      end
    end
    prev_rdy16 = if16.rx_ready;
  end

  always @(negedge clk) begin
    if (if4.frame_err) ferr4++;
    if (if4.rx_ready && !prev_rdy4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut4_unexpected_byte: got 0x%0h, expected no byte", if4.rx_data);
      end else begin
        check("dut4_rx_data", if4.rx_data, q4.pop_front());
      end
    end
    prev_rdy4 = if4.rx_ready;
  end

  // Reads each dut4 byte a couple of cycles after it appears.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack4 && if4.rx_ready) begin
        tick(2);
        if4.rx_ack = 1'b1;
        tick(1);
        if4.rx_ack = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int lat;
    if16.din = 1'b1; if16.rx_ack = 1'b0;
    if4.din  = 1'b1; if4.rx_ack  = 1'b0;
    tick(3);

    // Reset state
    check("reset_rx_data",    if16.rx_data,    8'h00);
    check("reset_rx_ready",   if16.rx_ready,   1'b0);
    check("reset_rx_overrun", if16.rx_overrun, 1'b0);
    check("reset_frame_err",  if16.frame_err,  1'b0);
    check("reset_rx_busy",    if16.rx_busy,    1'b0);
    rst_n = 1'b1;
    tick(4);

    // 1: clean frame, latency, ack clears ready
    q16.push_back(8'hA5);
    send_byte(0, 8'hA5, 1'b1);
    lat = rise_cyc16 - fall16;
    check($sformatf("t1_latency_%0d_in_153_155", lat), (lat >= 153 && lat <= 155), 1'b1);
    check("t1_ready_before_ack", if16.rx_ready, 1'b1);
    check("t1_no_frame_err", ferr16, 0);
    ack16();
    check("t1_ready_after_ack", if16.rx_ready, 1'b0);
    tick(16);

    // 2: bad stop bit, line held low, then a good frame
    f0 = ferr16;
    send_byte(0, 8'h3C, 1'b0);
    tick(100);
    check("t2_busy_while_low", if16.rx_busy, 1'b1);
    check("t2_one_frame_err", ferr16 - f0, 1);
    check("t2_ready_stays_0", if16.rx_ready, 1'b0);
    drive(0, 1'b1);
    tick(4);
    check("t2_idle_after_high", if16.rx_busy, 1'b0);
    check("t2_still_one_frame_err", ferr16 - f0, 1);
    q16.push_back(8'h55);
    send_byte(0, 8'h55, 1'b1);
    ack16();
    tick(16);

    // 3: 3-cycle glitch is rejected at mid start bit
    f0 = ferr16;
    drive(0, 1'b0);
    tick(3);
    drive(0, 1'b1);
    tick(3);
    check("t3_busy_in_start", if16.rx_busy, 1'b1);
    tick(6);
    check("t3_back_to_idle", if16.rx_busy, 1'b0);
    check("t3_no_ready", if16.rx_ready, 1'b0);
    check("t3_no_frame_err", ferr16 - f0, 0);
    q16.push_back(8'h81);
    send_byte(0, 8'h81, 1'b1);
    ack16();
    tick(16);

    // 4a: second byte while first unread -> overrun, newest kept
    q16.push_back(8'h11);
    send_byte(0, 8'h11, 1'b1);
    tick(8);
    send_byte(0, 8'h22, 1'b1);
    check("t4_overrun_set", if16.rx_overrun, 1'b1);
    check("t4_newest_data", if16.rx_data, 8'h22);
    check("t4_ready_held", if16.rx_ready, 1'b1);
    rst_n = 1'b0;
    tick(2);
    check("t4_reset_clears_overrun", if16.rx_overrun, 1'b0);
    rst_n = 1'b1;
    tick(4);

    // 4b: ack on the completion edge -> no overrun, ready stays set
    q16.push_back(8'h11);
    send_byte(0, 8'h11, 1'b1);
    tick(8);
    fork
      send_byte(0, 8'h22, 1'b1);
      begin
        tick(154);
        if16.rx_ack = 1'b1;
        tick(1);
        if16.rx_ack = 1'b0;
      end
    join
    check("t4b_no_overrun", if16.rx_overrun, 1'b0);
    check("t4b_ready_set", if16.rx_ready, 1'b1);
    check("t4b_data", if16.rx_data, 8'h22);

    // 5: reset in the middle of the data bits of 0xF0
    f0 = ferr16;
    fork
      send_byte(0, 8'hF0, 1'b1);
      begin
        tick(50);
        rst_n = 1'b0;
        #1;
        check("t5_rst_rx_data",    if16.rx_data,    8'h00);
        check("t5_rst_rx_ready",   if16.rx_ready,   1'b0);
        check("t5_rst_rx_overrun", if16.rx_overrun, 1'b0);
        check("t5_rst_rx_busy",    if16.rx_busy,    1'b0);
        check("t5_rst_frame_err",  if16.frame_err,  1'b0);
        tick(40);
        rst_n = 1'b1;
      end
    join
    tick(20);
    check("t5_no_spurious_ready", if16.rx_ready, 1'b0);
    check("t5_idle", if16.rx_busy, 1'b0);
    check("t5_no_frame_err", ferr16 - f0, 0);
    q16.push_back(8'h0F);
    send_byte(0, 8'h0F, 1'b1);
    check("t5_ready_0f", if16.rx_ready, 1'b1);
    ack16();
    tick(8);

    // 6: back-to-back frames at 4 clocks per bit
    auto_ack4 = 1'b1;
    q4.push_back(8'h00);
    q4.push_back(8'hFF);
    q4.push_back(8'h6B);
    send_byte(1, 8'h00, 1'b1);
    send_byte(1, 8'hFF, 1'b1);
    send_byte(1, 8'h6B, 1'b1);
    tick(10);
    check("t6_no_overrun", if4.rx_overrun, 1'b0);
    check("t6_no_frame_err", ferr4, 0);
    check("t6_all_acked", if4.rx_ready, 1'b0);
    check("t6_last_data", if4.rx_data, 8'h6B);

    // Scoreboards drained
    check("dut16_queue_empty", q16.size(), 0);
    check("dut4_queue_empty", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
